// File: rtl/hazard_control_unit_pkg.sv
// Shared constants and types for the pipeline hazard control unit:
// forwarding-select encodings, sequencer state encoding and the default register width.
package hazard_control_unit_pkg;

  localparam int unsigned REG_AW_DEFAULT = 3;

  // Operand mux select encoding (Mux4x2 sel); 2'b11 is never driven
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID-stage hazard inputs and pipeline control outputs of the hazard control unit.
// master = pipeline datapath side, slave = hazard control unit.
interface hazard_control_unit_if #(
  parameter int unsigned REG_AW = hazard_control_unit_pkg::REG_AW_DEFAULT,
  parameter int unsigned CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  perf_stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, ifid_flush, idex_bubble,
           perf_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, ifid_flush, idex_bubble,
           perf_stall_cnt
  );

endinterface

// File: rtl/hcu_fwd_mux_sel.sv
// Forwarding select for one EX operand: compares the operand's source register
// against the MEM and WB shadow slots; MEM wins over WB, loads in MEM never forward.
module hcu_fwd_mux_sel
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEFAULT,
  parameter bit          R0_IS_ZERO = 1'b1
) (
  input  logic              src_use_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_valid_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_valid_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired, so a read of it never needs a forwarded value
  assign src_live = src_use_i && !(R0_IS_ZERO && (src_i == '0));
  assign mem_hit  = src_live && mem_valid_i && mem_reg_write_i && (mem_rd_i == src_i);
  assign wb_hit   = src_live && wb_valid_i && wb_reg_write_i && (wb_rd_i == src_i);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_hit && !mem_mem_read_i) begin
      sel_o = FWD_EXMEM;
    end else if (wb_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: shadow rd-tag slots for EX/MEM/WB,
// operand forwarding selects, load-use stalls, taken-branch flushes and a stall counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEFAULT,
  parameter bit          R0_IS_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  bus
);

  // EX slot
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_reg_write_q;
  logic              ex_mem_read_q;
  logic [REG_AW-1:0] ex_rs1_q;
  logic [REG_AW-1:0] ex_rs2_q;
  logic              ex_use_rs1_q;
  logic              ex_use_rs2_q;
  // MEM slot
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_reg_write_q;
  logic              mem_mem_read_q;
  // WB slot
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_reg_write_q;

  hcu_state_e        state_q;
  hcu_state_e        state_d;
  logic [CNT_W-1:0]  perf_cnt_q;

  logic              load_use;
  logic              stall_event;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
    return (rd == src) && !(R0_IS_ZERO && (rd == '0));
  endfunction

  assign load_use = ex_valid_q && ex_mem_read_q && bus.id_valid &&
                    ((bus.id_use_rs1 && reg_match(ex_rd_q, bus.id_rs1)) ||
                     (bus.id_use_rs2 && reg_match(ex_rd_q, bus.id_rs2)));

  hcu_fwd_mux_sel #(
    .REG_AW     (REG_AW),
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_fwd_a (
    .src_use_i       (ex_valid_q && ex_use_rs1_q),
    .src_i           (ex_rs1_q),
    .mem_valid_i     (mem_valid_q),
    .mem_reg_write_i (mem_reg_write_q),
    .mem_mem_read_i  (mem_mem_read_q),
    .mem_rd_i        (mem_rd_q),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .sel_o           (fwd_a_sel)
  );

  hcu_fwd_mux_sel #(
    .REG_AW     (REG_AW),
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_fwd_b (
    .src_use_i       (ex_valid_q && ex_use_rs2_q),
    .src_i           (ex_rs2_q),
    .mem_valid_i     (mem_valid_q),
    .mem_reg_write_i (mem_reg_write_q),
    .mem_mem_read_i  (mem_mem_read_q),
    .mem_rd_i        (mem_rd_q),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .sel_o           (fwd_b_sel)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a taken branch overrides any stall request
  always_comb begin
    state_d = StRun;
    if (bus.ex_branch_taken) begin
      state_d = StFlush;
    end else if ((state_q == StRun) && load_use) begin
      state_d = StStall;
    end
  end

  // FSM: outputs; STALL and FLUSH behave as RUN once their event cycle is over
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_event = 1'b0;
    if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state_q == StRun) && load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_event = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_use_rs1_q    <= 1'b0;
      ex_use_rs2_q    <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      wb_valid_q      <= mem_valid_q;
      wb_rd_q         <= mem_rd_q;
      wb_reg_write_q  <= mem_reg_write_q;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_mem_read_q  <= ex_mem_read_q;
      if (idex_bubble) begin
        ex_valid_q     <= 1'b0;
        ex_rd_q        <= '0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_rs1_q       <= '0;
        ex_rs2_q       <= '0;
        ex_use_rs1_q   <= 1'b0;
        ex_use_rs2_q   <= 1'b0;
      end else begin
        ex_valid_q     <= bus.id_valid;
        ex_rd_q        <= bus.id_rd;
        ex_reg_write_q <= bus.id_reg_write;
        ex_mem_read_q  <= bus.id_mem_read;
        ex_rs1_q       <= bus.id_rs1;
        ex_rs2_q       <= bus.id_rs2;
        ex_use_rs1_q   <= bus.id_use_rs1;
        ex_use_rs2_q   <= bus.id_use_rs2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q <= '0;
    end else if (stall_event && (perf_cnt_q != {CNT_W{1'b1}})) begin
      perf_cnt_q <= perf_cnt_q + 1'b1;
    end
  end

  assign bus.fwd_a_sel      = fwd_a_sel;
  assign bus.fwd_b_sel      = fwd_b_sel;
  assign bus.pc_write       = pc_write;
  assign bus.ifid_write     = ifid_write;
  assign bus.ifid_flush     = ifid_flush;
  assign bus.idex_bubble    = idex_bubble;
  assign bus.perf_stall_cnt = perf_cnt_q;

  // A load sitting in MEM must never still have its consumer in EX
  a_no_load_in_mem_feeding_ex : assert property (@(posedge clk) disable iff (rst)
    !(mem_valid_q && mem_mem_read_q && ex_valid_q &&
      ((ex_use_rs1_q && reg_match(mem_rd_q, ex_rs1_q)) ||
       (ex_use_rs2_q && reg_match(mem_rd_q, ex_rs2_q)))));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two hazard units (R0 hardwired / 16-bit counter, and R0 ordinary /
// 2-bit counter) see identical stimulus and are checked against an instruction-level model.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use1;
    logic       use2;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_control_unit_if #(.REG_AW(3), .CNT_W(16)) bus_z ();
  hazard_control_unit_if #(.REG_AW(3), .CNT_W(2))  bus_n ();

  hazard_control_unit #(.REG_AW(3), .R0_IS_ZERO(1'b1), .CNT_W(16)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  hazard_control_unit #(.REG_AW(3), .R0_IS_ZERO(1'b0), .CNT_W(2)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  assign bus_n.id_valid        = bus_z.id_valid;
  assign bus_n.id_rs1          = bus_z.id_rs1;
  assign bus_n.id_rs2          = bus_z.id_rs2;
  assign bus_n.id_use_rs1      = bus_z.id_use_rs1;
  assign bus_n.id_use_rs2      = bus_z.id_use_rs2;
  assign bus_n.id_rd           = bus_z.id_rd;
  assign bus_n.id_reg_write    = bus_z.id_reg_write;
  assign bus_n.id_mem_read     = bus_z.id_mem_read;
  assign bus_n.ex_branch_taken = bus_z.ex_branch_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per unit, the instructions currently in EX (0), MEM (1), WB (2)
  instr_t      pipe [2][3];
  int unsigned mcnt [2];
  exp_t        q_z [$];
  exp_t        q_n [$];

  function automatic int unsigned cnt_max(input int k);
    return (k == 0) ? 32'd65535 : 32'd3;
  endfunction

  function automatic instr_t mk(input logic v, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic u1, input logic u2,
                                input logic rw, input logic mr);
    instr_t i;
    i.valid = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.use1 = u1; i.use2 = u2; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  // A register name refers to real storage unless it is R0 on the hardwired-zero unit
  function automatic bit same_reg(input logic [2:0] a, input logic [2:0] b, input bit z);
    return (a == b) && !(z && (a == 3'd0));
  endfunction

  function automatic logic [1:0] exp_fwd(input int k, input logic [2:0] src, input logic u);
    instr_t ex, mem, wb;
    bit z;
    z = (k == 0);
    ex = pipe[k][0]; mem = pipe[k][1]; wb = pipe[k][2];
    if (!ex.valid || !u) return 2'b00;
    if (mem.valid && mem.rw && !mem.mr && same_reg(mem.rd, src, z)) return 2'b01;
    if (wb.valid && wb.rw && same_reg(wb.rd, src, z)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_load_use(input int k, input instr_t id);
    instr_t ex;
    bit z;
    z = (k == 0);
    ex = pipe[k][0];
    return ex.valid && ex.mr && id.valid &&
           ((id.use1 && same_reg(ex.rd, id.rs1, z)) || (id.use2 && same_reg(ex.rd, id.rs2, z)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Drive one ID-stage cycle and queue the expected response of both units
  task automatic step(input instr_t id, input bit br, input bit r);
    @(negedge clk);
    #1;
    rst                   = r;
    bus_z.id_valid        = id.valid;
    bus_z.id_rd           = id.rd;
    bus_z.id_rs1          = id.rs1;
    bus_z.id_rs2          = id.rs2;
    bus_z.id_use_rs1      = id.use1;
    bus_z.id_use_rs2      = id.use2;
    bus_z.id_reg_write    = id.rw;
    bus_z.id_mem_read     = id.mr;
    bus_z.ex_branch_taken = br;
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   stall;
      if (r) begin
        for (int j = 0; j < 3; j++) pipe[k][j] = '0;
        mcnt[k] = 0;
      end
      stall = exp_load_use(k, id) && !br;
      e.fa  = exp_fwd(k, pipe[k][0].rs1, pipe[k][0].use1);
      e.fb  = exp_fwd(k, pipe[k][0].rs2, pipe[k][0].use2);
      e.pcw = !stall;
      e.ifw = !stall;
      e.fl  = br;
      e.bub = br || stall;
      e.cnt = 16'(mcnt[k]);
      if (k == 0) q_z.push_back(e);
      else q_n.push_back(e);
      if (!r) begin
        if (stall && (mcnt[k] < cnt_max(k))) mcnt[k]++;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = (br || stall) ? instr_t'('0) : id;
      end
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [1:0] fa, input logic [1:0] fb,
                     input logic pcw, input logic ifw, input logic fl, input logic bub,
                     input logic [15:0] cnt);
    check({tag, " fwd_a_sel"}, 32'(fa), 32'(e.fa));
    check({tag, " fwd_b_sel"}, 32'(fb), 32'(e.fb));
    check({tag, " pc_write"}, 32'(pcw), 32'(e.pcw));
    check({tag, " ifid_write"}, 32'(ifw), 32'(e.ifw));
    check({tag, " ifid_flush"}, 32'(fl), 32'(e.fl));
    check({tag, " idex_bubble"}, 32'(bub), 32'(e.bub));
    check({tag, " perf_stall_cnt"}, 32'(cnt), 32'(e.cnt));
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    while (q_z.size() > 0) begin
      e = q_z.pop_front();
      cmp("z", e, bus_z.fwd_a_sel, bus_z.fwd_b_sel, bus_z.pc_write, bus_z.ifid_write,
          bus_z.ifid_flush, bus_z.idex_bubble, bus_z.perf_stall_cnt);
    end
    while (q_n.size() > 0) begin
      e = q_n.pop_front();
      cmp("n", e, bus_n.fwd_a_sel, bus_n.fwd_b_sel, bus_n.pc_write, bus_n.ifid_write,
          bus_n.ifid_flush, bus_n.idex_bubble, 16'(bus_n.perf_stall_cnt));
    end
  end

  initial begin : driver
    instr_t nop, ld_r2, dep_r2, ld_r0, use_r0;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_z.id_valid = 1'b0; bus_z.id_rd = '0; bus_z.id_rs1 = '0; bus_z.id_rs2 = '0;
    bus_z.id_use_rs1 = 1'b0; bus_z.id_use_rs2 = 1'b0; bus_z.id_reg_write = 1'b0;
    bus_z.id_mem_read = 1'b0; bus_z.ex_branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) pipe[k][j] = '0;
      mcnt[k] = 0;
    end
    nop    = '0;
    ld_r2  = mk(1, 3'd2, 3'd3, 3'd0, 1, 0, 1, 1);
    dep_r2 = mk(1, 3'd6, 3'd2, 3'd2, 1, 1, 1, 0);
    ld_r0  = mk(1, 3'd0, 3'd1, 3'd0, 1, 0, 1, 1);
    use_r0 = mk(1, 3'd3, 3'd0, 3'd0, 1, 1, 1, 0);

    // Reset values
    step(nop, 0, 1);
    #1;
    check("reset pc_write", 32'(bus_z.pc_write), 32'd1);
    check("reset idex_bubble", 32'(bus_z.idex_bubble), 32'd0);
    step(nop, 0, 0);

    // EX/MEM forward, back-to-back
    step(mk(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0), 0, 0);
    step(mk(1, 3'd2, 3'd1, 3'd3, 1, 1, 1, 0), 0, 0);
    step(nop, 0, 0);
    #1;
    check("t1 fwd_a_sel", 32'(bus_z.fwd_a_sel), 32'd1);
    check("t1 pc_write", 32'(bus_z.pc_write), 32'd1);

    // MEM/WB forward, then MEM wins over WB
    step(mk(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0), 0, 0);
    step(nop, 0, 0);
    step(mk(1, 3'd4, 3'd1, 3'd5, 1, 1, 1, 0), 0, 0);
    step(nop, 0, 0);
    #1;
    check("t2 fwd_a_sel wb", 32'(bus_z.fwd_a_sel), 32'd2);
    step(mk(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0), 0, 0);
    step(mk(1, 3'd1, 3'd6, 3'd7, 1, 1, 1, 0), 0, 0);
    step(mk(1, 3'd4, 3'd1, 3'd5, 1, 1, 1, 0), 0, 0);
    step(nop, 0, 0);
    #1;
    check("t2 fwd_a_sel mem", 32'(bus_z.fwd_a_sel), 32'd1);

    // Load-use stall, then MEM/WB forward of the load result
    step(ld_r2, 0, 0);
    step(dep_r2, 0, 0);
    #1;
    check("t3 pc_write", 32'(bus_z.pc_write), 32'd0);
    check("t3 ifid_write", 32'(bus_z.ifid_write), 32'd0);
    check("t3 idex_bubble", 32'(bus_z.idex_bubble), 32'd1);
    check("t3 cnt before", 32'(bus_z.perf_stall_cnt), 32'd0);
    step(dep_r2, 0, 0);
    #1;
    check("t3 cnt after", 32'(bus_z.perf_stall_cnt), 32'd1);
    step(nop, 0, 0);
    #1;
    check("t3 fwd_a_sel", 32'(bus_z.fwd_a_sel), 32'd2);
    check("t3 fwd_b_sel", 32'(bus_z.fwd_b_sel), 32'd2);

    // Branch beats load-use
    step(ld_r2, 0, 0);
    step(dep_r2, 1, 0);
    #1;
    check("t4 ifid_flush", 32'(bus_z.ifid_flush), 32'd1);
    check("t4 idex_bubble", 32'(bus_z.idex_bubble), 32'd1);
    check("t4 pc_write", 32'(bus_z.pc_write), 32'd1);
    step(nop, 0, 0);
    #1;
    check("t4 cnt", 32'(bus_z.perf_stall_cnt), 32'd1);
    check("t4 ifid_flush next", 32'(bus_z.ifid_flush), 32'd0);

    // R0: no hazard when hardwired, stall otherwise
    step(ld_r0, 0, 0);
    step(use_r0, 0, 0);
    #1;
    check("t5 z pc_write", 32'(bus_z.pc_write), 32'd1);
    check("t5 n pc_write", 32'(bus_n.pc_write), 32'd0);
    step(use_r0, 0, 0);
    step(nop, 0, 0);
    #1;
    check("t5 z fwd_a_sel", 32'(bus_z.fwd_a_sel), 32'd0);
    check("t5 n fwd_a_sel", 32'(bus_n.fwd_a_sel), 32'd2);

    // Counter saturation on the 2-bit unit
    repeat (3) begin
      step(ld_r2, 0, 0);
      step(dep_r2, 0, 0);
      step(dep_r2, 0, 0);
    end
    step(nop, 0, 0);
    #1;
    check("t6 z cnt", 32'(bus_z.perf_stall_cnt), 32'd4);
    check("t6 n cnt saturated", 32'(bus_n.perf_stall_cnt), 32'd3);

    // Reset while in STALL
    step(ld_r2, 0, 0);
    step(dep_r2, 0, 0);
    step(dep_r2, 0, 1);
    #1;
    check("t6 rst pc_write", 32'(bus_z.pc_write), 32'd1);
    check("t6 rst idex_bubble", 32'(bus_z.idex_bubble), 32'd0);
    check("t6 rst cnt", 32'(bus_z.perf_stall_cnt), 32'd0);
    step(dep_r2, 0, 0);
    #1;
    check("t6 post-rst no stall", 32'(bus_z.pc_write), 32'd1);

    // Randomised traffic with occasional branches and resets
    for (int c = 0; c < 3000; c++) begin
      instr_t id;
      id = mk(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      step(id, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
    end

    step(nop, 0, 0);
    @(negedge clk);
    #3;
    check("scoreboard z drained", 32'(q_z.size()), 32'd0);
    check("scoreboard n drained", 32'(q_n.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
